// File: rtl/scie_fir_sequencer.sv
// Operand-pair sequencer for the pipelined complex-FIR custom instruction unit.
// Optional `SCIE_SEQ_PERF_CNT_EN adds perf_done / perf_stall counters.
module scie_fir_sequencer #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NTAPS      = 5,
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [6:0]  OPC_LOAD_A = 7'h0B,
  parameter logic [6:0]  OPC_LOAD_B = 7'h2B,
  parameter logic [6:0]  OPC_EXEC   = 7'h5B
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            busy,
  output logic            scie_valid,
  output logic [31:0]     scie_insn,
  output logic [XLEN-1:0] scie_rs1,
  output logic [XLEN-1:0] scie_rs2,
  input  logic [XLEN-1:0] scie_rd
`ifdef SCIE_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]     perf_done,
  output logic [31:0]     perf_stall
`endif
);

  localparam int unsigned IDX_W  = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int unsigned WCNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_LOAD, S_ISSUE_A, S_ISSUE_B, S_EXEC, S_WAIT, S_HOLD
  } state_t;

  state_t            state_q, state_n;
  logic [IDX_W-1:0]  idx_q, idx_n;
  logic [WCNT_W-1:0] wcnt_q, wcnt_n;
  logic [XLEN-1:0]   a_q, a_n, b_q, b_n, data_n;
  logic              in_ready_n, out_valid_n, busy_n, scie_valid_n;
  logic [31:0]       scie_insn_n;
  logic [XLEN-1:0]   scie_rs1_n, scie_rs2_n;

  // Next state, then every output decoded from the next state so all ports are flops
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    wcnt_n  = wcnt_q;
    a_n     = a_q;
    b_n     = b_q;
    data_n  = out_data;
    unique case (state_q)
      S_LOAD: begin
        if (in_valid && in_ready) begin
          a_n     = in_a;
          b_n     = in_b;
          state_n = S_ISSUE_A;
        end
      end
      S_ISSUE_A: state_n = S_ISSUE_B;
      S_ISSUE_B: begin
        if (idx_q == IDX_W'(NTAPS - 1)) begin
          state_n = S_EXEC;
        end else begin
          idx_n   = idx_q + IDX_W'(1);
          state_n = S_LOAD;
        end
      end
      S_EXEC: begin
        wcnt_n  = WCNT_W'(RD_LATENCY - 1);
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == '0) begin
          data_n  = scie_rd;
          state_n = S_HOLD;
        end else begin
          wcnt_n = wcnt_q - WCNT_W'(1);
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          idx_n   = '0;
          state_n = S_LOAD;
        end
      end
      default: state_n = S_LOAD;
    endcase

    in_ready_n   = (state_n == S_LOAD);
    out_valid_n  = (state_n == S_HOLD);
    busy_n       = !((state_n == S_LOAD) && (idx_n == '0));
    scie_valid_n = 1'b0;
    scie_insn_n  = '0;
    scie_rs1_n   = '0;
    scie_rs2_n   = '0;
    unique case (state_n)
      S_ISSUE_A: begin
        scie_valid_n = 1'b1;
        scie_insn_n  = 32'(OPC_LOAD_A);
        scie_rs1_n   = a_n;
        scie_rs2_n   = XLEN'(idx_n);
      end
      S_ISSUE_B: begin
        scie_valid_n = 1'b1;
        scie_insn_n  = 32'(OPC_LOAD_B);
        scie_rs1_n   = b_n;
        scie_rs2_n   = XLEN'(idx_n);
      end
      S_EXEC: begin
        scie_valid_n = 1'b1;
        scie_insn_n  = 32'(OPC_EXEC);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_LOAD;
      idx_q      <= '0;
      wcnt_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      busy       <= 1'b0;
      scie_valid <= 1'b0;
      scie_insn  <= '0;
      scie_rs1   <= '0;
      scie_rs2   <= '0;
    end else begin
      state_q    <= state_n;
      idx_q      <= idx_n;
      wcnt_q     <= wcnt_n;
      a_q        <= a_n;
      b_q        <= b_n;
      in_ready   <= in_ready_n;
      out_valid  <= out_valid_n;
      out_data   <= data_n;
      busy       <= busy_n;
      scie_valid <= scie_valid_n;
      scie_insn  <= scie_insn_n;
      scie_rs1   <= scie_rs1_n;
      scie_rs2   <= scie_rs2_n;
    end
  end

`ifdef SCIE_SEQ_PERF_CNT_EN
  // Completed results and cycles the consumer left a result waiting
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_done  <= '0;
      perf_stall <= '0;
    end else if (state_q == S_HOLD) begin
      if (out_ready) perf_done  <= perf_done + 32'd1;
      else           perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
